// File: rtl/shift_right_seq.sv
// shift_right_seq
// Sequential symbol right-shifter. Accepts a 50-bit word of ten 5-bit symbols,
// shifts it right by up to 10 symbols using an external combinational shifter
// that handles at most 4 symbols per pass, and returns the result with a
// valid/ready handshake. Amounts above 10 are clamped and flagged as errors.
module shift_right_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [49:0] in_data,
    input  logic [3:0]  in_amt,
    input  logic [4:0]  in_fill,
    output logic [49:0] sh_in,
    output logic [2:0]  sh_shift,
    output logic [4:0]  sh_fill,
    input  logic [49:0] sh_out,
    input  logic        sh_out_valid,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [49:0] out_data,
    output logic        out_err,
    output logic        busy
);

    localparam logic [3:0] MAX_AMT  = 4'd10;
    localparam logic [3:0] MAX_PASS = 4'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [49:0] data_q,  data_d;
    logic [4:0]  fill_q,  fill_d;
    logic [3:0]  rem_q,   rem_d;
    logic        err_q,   err_d;

    logic [3:0]  amt_clamp;
    logic [2:0]  pass_amt;
    logic [3:0]  rem_after;

    // Clamped request amount, this pass's shift, and what is left afterwards.
    assign amt_clamp = (in_amt > MAX_AMT) ? MAX_AMT : in_amt;
    assign pass_amt  = (rem_q > MAX_PASS) ? 3'd4 : rem_q[2:0];
    assign rem_after = rem_q - {1'b0, pass_amt};

    // Next-state and datapath update for the IDLE -> SHIFT -> DONE sequence.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        fill_d  = fill_q;
        rem_d   = rem_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    fill_d  = in_fill;
                    rem_d   = amt_clamp;
                    err_d   = (in_amt > MAX_AMT);
                    state_d = (amt_clamp == 4'd0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                data_d = sh_out;
                rem_d  = rem_after;
                // A shifter fault taints the whole request, not just this pass.
                if (!sh_out_valid) begin
                    err_d = 1'b1;
                end
                if (rem_after == 4'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any request in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            fill_q  <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            fill_q  <= fill_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    // in_ready is gated by rst because the state register already reads IDLE
    // while reset is held, and no request may be taken then.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = data_q;
    assign out_err   = err_q;

    // The shifter sees the registers at all times but only shifts in SHIFT.
    assign sh_in    = data_q;
    assign sh_fill  = fill_q;
    assign sh_shift = (state_q == SHIFT) ? pass_amt : 3'd0;

endmodule

// File: tb/tb_shift_right_seq.sv
// Testbench for shift_right_seq: models the external shifter, runs a table of
// directed requests, hand-written corner sequences and randomized requests
// against a reference model of the symbol shift.
module tb_shift_right_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [49:0] in_data;
    logic [3:0]  in_amt;
    logic [4:0]  in_fill;
    logic [49:0] sh_in;
    logic [2:0]  sh_shift;
    logic [4:0]  sh_fill;
    logic [49:0] sh_out;
    logic        sh_out_valid;
    logic        out_valid;
    logic        out_ready;
    logic [49:0] out_data;
    logic        out_err;
    logic        busy;

    bit          bad_pass = 1'b0;
    int          checks = 0;
    int          errors = 0;

    shift_right_seq dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_amt       (in_amt),
        .in_fill      (in_fill),
        .sh_in        (sh_in),
        .sh_shift     (sh_shift),
        .sh_fill      (sh_fill),
        .sh_out       (sh_out),
        .sh_out_valid (sh_out_valid),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_err      (out_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // External combinational shifter: right shift by sh_shift symbols with fill.
    always_comb begin
        int j;
        sh_out = '0;
        for (int k = 0; k < 10; k++) begin
            j = k + int'(sh_shift);
            if (j <= 9) sh_out[5*k +: 5] = sh_in[5*j +: 5];
            else        sh_out[5*k +: 5] = sh_fill;
        end
        sh_out_valid = (sh_shift <= 3'd4) && !bad_pass;
    end

    typedef struct {
        logic [49:0] d;
        int          amt;
        logic [4:0]  f;
        bit          bad;
        logic [49:0] exp_d;
        bit          exp_e;
        int          exp_p;
    } vec_t;

    // Reference: shift the whole word right by 5n bits, then fill the top n symbols.
    function automatic logic [49:0] ref_shift(input logic [49:0] d, input int amt, input logic [4:0] f);
        int n;
        logic [49:0] r;
        n = (amt > 10) ? 10 : amt;
        r = d >> (5 * n);
        for (int k = 10 - n; k < 10; k++) r[5*k +: 5] = f;
        return r;
    endfunction

    function automatic int ref_passes(input int amt);
        int n;
        n = (amt > 10) ? 10 : amt;
        return (n + 3) / 4;
    endfunction

    function automatic logic [49:0] rnd50();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[49:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One complete request with out_ready held high.
    task automatic do_req(input string tag, input logic [49:0] d, input int amt, input logic [4:0] f,
                          input bit bad, input logic [49:0] exp_d, input bit exp_e, input int exp_p);
        int guard, lat, r, exp_s, shmis;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        chk({tag, " ready_before"}, 64'(in_ready), 64'd1);
        in_data  = d;
        in_amt   = 4'(amt);
        in_fill  = f;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Inputs after the accept edge must not matter.
        in_data  = rnd50();
        in_amt   = 4'($urandom_range(0, 15));
        in_fill  = 5'($urandom_range(0, 31));
        lat   = 0;
        shmis = 0;
        r     = (amt > 10) ? 10 : amt;
        while (!out_valid && lat < 20) begin
            exp_s = (r > 4) ? 4 : r;
            if (int'(sh_shift) != exp_s) shmis++;
            r -= exp_s;
            if (bad && lat == 0) bad_pass = 1'b1;
            @(posedge clk); #1;
            bad_pass = 1'b0;
            lat++;
        end
        chk({tag, " latency"}, 64'(lat + 1), 64'(exp_p + 1));
        chk({tag, " sh_shift_seq"}, 64'(shmis), 64'd0);
        chk({tag, " out_data"}, 64'(out_data), 64'(exp_d));
        chk({tag, " out_err"}, 64'(out_err), 64'(exp_e));
        chk({tag, " done_shift0"}, 64'(sh_shift), 64'd0);
        @(posedge clk); #1;
        chk({tag, " idle_after"}, 64'({out_valid, in_ready, busy}), 64'b010);
    endtask

    vec_t        tbl[7];
    logic [49:0] seq_d, d, held;
    int          amt, guard;
    bit          bad;
    logic [4:0]  f;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_fill   = '0;
        out_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("reset_outs", 64'({in_ready, out_valid, out_err, busy, sh_shift}), 64'd0);
        chk("reset_data", 64'(out_data), 64'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 64'(in_ready), 64'd1);

        seq_d = {5'd10, 5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1};
        tbl[0] = '{seq_d, 6,  5'h1F, 1'b0, {{6{5'h1F}}, 5'd10, 5'd9, 5'd8, 5'd7}, 1'b0, 2};
        tbl[1] = '{seq_d, 0,  5'h1F, 1'b0, seq_d, 1'b0, 0};
        tbl[2] = '{seq_d, 10, 5'h0A, 1'b0, {10{5'h0A}}, 1'b0, 3};
        tbl[3] = '{seq_d, 13, 5'h0A, 1'b0, {10{5'h0A}}, 1'b1, 3};
        tbl[4] = '{seq_d, 4,  5'h00, 1'b0, {20'd0, 5'd10, 5'd9, 5'd8, 5'd7, 5'd6, 5'd5}, 1'b0, 1};
        tbl[5] = '{seq_d, 1,  5'h15, 1'b0, {5'h15, 5'd10, 5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2}, 1'b0, 1};
        tbl[6] = '{seq_d, 5,  5'h03, 1'b1, {{5{5'h03}}, 5'd10, 5'd9, 5'd8, 5'd7, 5'd6}, 1'b1, 2};
        for (int i = 0; i < 7; i++) begin
            do_req($sformatf("vec%0d", i), tbl[i].d, tbl[i].amt, tbl[i].f, tbl[i].bad,
                   tbl[i].exp_d, tbl[i].exp_e, tbl[i].exp_p);
        end

        // Backpressure in DONE: result held, new requests ignored.
        out_ready = 1'b0;
        d         = rnd50();
        in_data   = d;
        in_amt    = 4'd3;
        in_fill   = 5'h11;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        chk("bp_valid", 64'(out_valid), 64'd1);
        held = ref_shift(d, 3, 5'h11);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = rnd50();
            in_amt   = 4'd7;
            @(posedge clk); #1;
            chk($sformatf("bp_hold%0d", c), 64'({out_valid, in_ready, busy}), 64'b101);
            chk($sformatf("bp_data%0d", c), 64'(out_data), 64'(held));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", 64'({out_valid, in_ready, busy}), 64'b010);

        // Reset pulse in the middle of a 3-pass request.
        in_data  = seq_d;
        in_amt   = 4'd9;
        in_fill  = 5'h07;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("midrst_in_shift", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("midrst_outs", 64'({busy, out_valid, in_ready, out_err, sh_shift}), 64'd0);
        chk("midrst_data", 64'(out_data), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst_ready", 64'(in_ready), 64'd1);
        do_req("after_rst", seq_d, 9, 5'h07, 1'b0, ref_shift(seq_d, 9, 5'h07), 1'b0, 3);

        // Randomized requests against the reference model.
        for (int i = 0; i < 40; i++) begin
            d   = rnd50();
            amt = $urandom_range(0, 15);
            f   = 5'($urandom_range(0, 31));
            bad = ($urandom_range(0, 7) == 0);
            do_req($sformatf("rnd%0d", i), d, amt, f, bad, ref_shift(d, amt, f),
                   (amt > 10) || (bad && ref_passes(amt) > 0), ref_passes(amt));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
